// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: bus-programmable RGB PWM with a hardware fade (breathing) engine.
// rgb_pwm_lane holds one channel's active duty, level scaling and output flop.

module rgb_pwm_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                run,
  input  logic [PWM_BITS-1:0] shadow,
  input  logic [PWM_BITS-1:0] level,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm
);
  localparam int PW = 2*PWM_BITS + 1;

  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS:0]   lvl_p1;
  logic [PW-1:0]       prod;
  logic [PWM_BITS:0]   eff;

  // level+1 makes level 255 an exact pass-through and level 0 fully dark.
  assign lvl_p1 = {1'b0, level} + {{PWM_BITS{1'b0}}, 1'b1};
  assign prod   = PW'(duty) * PW'(lvl_p1);
  assign eff    = prod[PW-1:PWM_BITS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      if (load) duty <= shadow;
      pwm <= run & ({1'b0, pwm_cnt} < eff);
    end
  end
endmodule

module rgb_pwm_ctrl #(
  parameter int PWM_BITS   = 8,
  parameter int PRESC_BITS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [2:0]  rgb_pwm,
  output logic        done
);
  localparam int NUM_LANES = 3;
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

  typedef enum logic [1:0] {
    S_OFF       = 2'd0,
    S_STATIC    = 2'd1,
    S_RAMP_UP   = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  typedef struct packed {
    logic [PRESC_BITS-1:0] presc;
    logic                  oneshot;
    logic                  breathe;
    logic                  en;
  } ctrl_t;

  ctrl_t                              ctrl, ctrl_nxt;
  logic [NUM_LANES-1:0][PWM_BITS-1:0] duty_sh;
  logic [15:0]                        step;
  state_t                             state, state_nxt;
  logic [PWM_BITS-1:0]                level, level_nxt, pwm_cnt;
  logic [PRESC_BITS-1:0]              presc_cnt;
  logic [15:0]                        frame_cnt;
  logic [31:0]                        rd_data;
  logic wr, rd, wr_ctrl, wr_duty, wr_step, wr_stat;
  logic tick, frame, ramping, step_evt, en_rise, done_set, duty_load, hold;

  assign wr      = cs & we;
  assign rd      = cs & ~we;
  assign wr_ctrl = wr && (addr == 2'd0);
  assign wr_duty = wr && (addr == 2'd1);
  assign wr_step = wr && (addr == 2'd2);
  assign wr_stat = wr && (addr == 2'd3);

  // Look-ahead control word: enable/disable and mode take effect on the write edge.
  assign ctrl_nxt  = wr_ctrl ? {din[16 +: PRESC_BITS], din[2:0]} : ctrl;
  assign en_rise   = ctrl_nxt.en & ~ctrl.en;
  assign hold      = ~ctrl_nxt.en | (state == S_OFF);
  assign ramping   = (state == S_RAMP_UP) || (state == S_RAMP_DOWN);
  assign tick      = (state != S_OFF) && (presc_cnt >= ctrl.presc);
  assign frame     = tick && (pwm_cnt == PWM_MAX);
  assign step_evt  = frame && ramping && (frame_cnt >= step);
  assign duty_load = frame | en_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_OFF;
      level <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    done_set  = 1'b0;
    if (!ctrl_nxt.en) begin
      state_nxt = S_OFF;
      level_nxt = '0;
    end else begin
      case (state)
        S_OFF: begin
          if (!ctrl_nxt.breathe && !ctrl_nxt.oneshot) begin
            state_nxt = S_STATIC;
            level_nxt = PWM_MAX;
          end else begin
            state_nxt = S_RAMP_UP;
          end
        end
        S_STATIC: level_nxt = PWM_MAX;
        S_RAMP_UP: begin
          if (step_evt) begin
            if (!ctrl_nxt.breathe && !ctrl_nxt.oneshot) begin
              state_nxt = S_STATIC;
              level_nxt = PWM_MAX;
            end else begin
              level_nxt = level + 1'b1;
              // oneshot wins over breathe at the top of the ramp
              if (level == PWM_MAX - PWM_ONE) begin
                if (ctrl_nxt.oneshot) begin
                  state_nxt = S_STATIC;
                  done_set  = 1'b1;
                end else begin
                  state_nxt = S_RAMP_DOWN;
                end
              end
            end
          end
        end
        S_RAMP_DOWN: begin
          if (step_evt) begin
            if (!ctrl_nxt.breathe && !ctrl_nxt.oneshot) begin
              state_nxt = S_STATIC;
              level_nxt = PWM_MAX;
            end else begin
              level_nxt = level - 1'b1;
              if (level == PWM_ONE) state_nxt = S_RAMP_UP;
            end
          end
        end
        default: state_nxt = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      frame_cnt <= '0;
    end else if (hold) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (!ramping || step_evt) frame_cnt <= '0;
      else if (frame)           frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      2'd0: begin
        rd_data[16 +: PRESC_BITS] = ctrl.presc;
        rd_data[2:0]              = {ctrl.oneshot, ctrl.breathe, ctrl.en};
      end
      2'd1:    rd_data[NUM_LANES*PWM_BITS-1:0] = duty_sh;
      2'd2:    rd_data[15:0] = step;
      default: begin
        rd_data[1:0]          = state;
        rd_data[8 +: PWM_BITS] = level;
        rd_data[16]           = done;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl    <= '0;
      duty_sh <= '0;
      step    <= '0;
      done    <= 1'b0;
      dout    <= '0;
    end else begin
      ctrl <= ctrl_nxt;
      if (wr_duty) duty_sh <= din[NUM_LANES*PWM_BITS-1:0];
      if (wr_step) step <= din[15:0];
      if (done_set)                done <= 1'b1;
      else if (wr_stat && din[16]) done <= 1'b0;
      if (rd) dout <= rd_data;
    end
  end

  genvar c;
  generate
    for (c = 0; c < NUM_LANES; c++) begin : g_lane
      rgb_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (duty_load),
        .run     (ctrl_nxt.en),
        .shadow  (duty_sh[c]),
        .level   (level),
        .pwm_cnt (pwm_cnt),
        .pwm     (rgb_pwm[c])
      );
    end
  endgenerate
endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Self-checking bench for rgb_pwm_ctrl: register reads go through a scoreboard
// queue; PWM duty and fade levels come from a frame/step arithmetic model.

module tb_rgb_pwm_ctrl;
  logic        clk;
  logic        reset_n;
  logic        cs, we;
  logic [1:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [2:0]  rgb_pwm;
  logic        done;

  rgb_pwm_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .addr(addr),
    .din(din), .dout(dout), .rgb_pwm(rgb_pwm), .done(done)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   en_cyc = 0;
  logic rd_q   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_q <= reset_n & cs & ~we;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Monitor: a read response appears on dout one cycle after cs & !we.
  always @(negedge clk) begin
    if (rd_q) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: read response 0x%08h with no expectation", dout);
      end else begin
        rd_exp_t e;
        e = sbq.pop_front();
        chk(e.name, dout, e.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // Cycle index since the enabling write; counters are 0 in cycle 0.
  function automatic int kidx();
    return cyc - en_cyc;
  endfunction

  // Ramp-up STATUS: one level per (step+1) frames, oneshot completes at 255.
  function automatic logic [31:0] stat_exp(input int k, input int stp);
    int s;
    logic [31:0] r;
    s = (k / 256) / (stp + 1);
    r = '0;
    if (s >= 255) begin
      r[15:8] = 8'hFF;
      r[1:0]  = 2'd1;
      r[16]   = 1'b1;
    end else begin
      r[15:8] = s[7:0];
      r[1:0]  = 2'd2;
    end
    return r;
  endfunction

  function automatic int eff(input int d, input int lvl);
    return (d * (lvl + 1)) / 256;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    rd_exp_t x;
    x.name = nm;
    x.exp  = e;
    sbq.push_back(x);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic wait_k(input int t);
    while (kidx() < t) @(negedge clk);
  endtask

  task automatic count_rgb(input int n, output int cr, output int cg, output int cb);
    cr = 0; cg = 0; cb = 0;
    repeat (n) begin
      @(negedge clk);
      cr += int'(rgb_pwm[0]);
      cg += int'(rgb_pwm[1]);
      cb += int'(rgb_pwm[2]);
    end
  endtask

  initial begin
    int p, nfr, k, c, cr, cg, cb, errs, newcnt, j, dr;
    logic [31:0] d;
    logic [7:0]  g, b;

    reset_n = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", {29'b0, rgb_pwm}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_dout", dout, 0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) rd(a[1:0], 32'h0, "rst_reg");

    // Static duty: test-plan pattern first, then random duty/prescaler.
    for (int it = 0; it < 4; it++) begin
      p   = (it == 0) ? 0 : $urandom_range(0, 2);
      d   = (it == 0) ? 32'h00FF_8000 : ($urandom() & 32'h00FF_FFFF);
      nfr = (it == 0) ? 3 : 2;
      wr(2'd0, 32'h0);
      wr(2'd1, d);
      wr(2'd0, {p[15:0], 16'h0001});
      en_cyc = cyc;
      count_rgb(nfr * 256 * (p + 1), cr, cg, cb);
      chk("static_r", cr, nfr * (p + 1) * int'(d[7:0]));
      chk("static_g", cg, nfr * (p + 1) * int'(d[15:8]));
      chk("static_b", cb, nfr * (p + 1) * int'(d[23:16]));
      rd(2'd0, {p[15:0], 16'h0001}, "ctrl_rb");
      rd(2'd1, d, "duty_rb");
      rd(2'd3, 32'h0000_FF01, "static_status");
    end

    // Shadowing: a mid-frame DUTY write only takes effect at the next pwm_cnt=0.
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h0000_00C0);
    wr(2'd0, 32'h0000_0001);
    en_cyc = cyc;
    c = $urandom_range(260, 480);
    wait_k(c);
    wr(2'd1, 32'h0000_0040);
    errs = 0; newcnt = 0;
    while (kidx() < 812) begin
      @(negedge clk);
      j  = kidx() - 1;
      dr = (j >= 512) ? 64 : 192;
      if (rgb_pwm !== {2'b00, ((j % 256) < dr)}) errs++;
      if (j >= 512 && j < 768) newcnt += int'(rgb_pwm[0]);
    end
    chk("shadow_wave_errs", errs, 0);
    chk("shadow_new_cnt", newcnt, 64);

    // Disable while the output is high.
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h0000_00FF);
    wr(2'd0, 32'h0000_0001);
    en_cyc = cyc;
    wait_k($urandom_range(100, 200));
    chk("dis_pre_r", {31'b0, rgb_pwm[0]}, 1);
    wr(2'd0, 32'h0);
    chk("dis_rgb", {29'b0, rgb_pwm}, 0);
    rd(2'd3, 32'h0, "dis_status");

    // One-shot fade with breathe also set: oneshot must win at the top.
    g = 8'($urandom());
    b = 8'($urandom());
    wr(2'd1, {8'h00, b, g, 8'hFF});
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h0000_0007);
    en_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        wait_k(100 * 256);
        count_rgb(256, cr, cg, cb);
        chk("lvl100_r", cr, eff(255, 100));
        chk("lvl100_g", cg, eff(int'(g), 100));
        chk("lvl100_b", cb, eff(int'(b), 100));
      end
      wait_k(i * 8000 + $urandom_range(0, 7000));
      rd(2'd3, stat_exp(kidx(), 0), "ramp_status");
    end
    wait_k(65279);
    chk("done_pre", {31'b0, done}, 0);
    rd(2'd3, stat_exp(kidx(), 0), "ramp_254");
    rd(2'd3, stat_exp(kidx(), 0), "ramp_255");
    chk("done_set", {31'b0, done}, 1);
    wait_k(256 * 256);
    count_rgb(256, cr, cg, cb);
    chk("full_r", cr, 255);
    chk("full_g", cg, int'(g));
    chk("full_b", cb, int'(b));
    wr(2'd3, 32'h0);
    chk("done_hold", {31'b0, done}, 1);
    wr(2'd3, 32'h0001_0000);
    chk("done_clr", {31'b0, done}, 0);
    rd(2'd3, 32'h0000_FF01, "status_after_clr");

    // Breathe, two frames per level, then drop both mode bits mid-ramp.
    wr(2'd0, 32'h0);
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h0000_0003);
    en_cyc = cyc;
    rd(2'd2, 32'h1, "step_rb");
    for (int i = 0; i < 4; i++) begin
      wait_k(i * 270 + $urandom_range(0, 200));
      rd(2'd3, stat_exp(kidx(), 1), "breathe_status");
    end
    c = $urandom_range(1100, 1300);
    wait_k(c);
    wr(2'd0, 32'h0000_0001);
    wait_k($urandom_range(c + 1, 1535));
    rd(2'd3, stat_exp(kidx(), 1), "mode_pending");
    wait_k(1540);
    rd(2'd3, 32'h0000_FF01, "mode_static");
    chk("mode_no_done", {31'b0, done}, 0);

    // Disable mid-ramp, then re-enable from level 0.
    wr(2'd0, 32'h0);
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h0000_0003);
    en_cyc = cyc;
    wait_k($urandom_range(768, 968));
    rd(2'd3, stat_exp(kidx(), 0), "pre_dis_status");
    wr(2'd0, 32'h0);
    chk("dis_ramp_rgb", {29'b0, rgb_pwm}, 0);
    rd(2'd3, 32'h0, "dis_ramp_status");
    wr(2'd0, 32'h0000_0003);
    en_cyc = cyc;
    rd(2'd3, stat_exp(kidx(), 0), "reen_status0");
    wait_k($urandom_range(256, 456));
    rd(2'd3, stat_exp(kidx(), 0), "reen_status1");

    // Asynchronous reset while an output is high and dout is non-zero.
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h0000_00FF);
    wr(2'd0, 32'h0000_0001);
    en_cyc = cyc;
    rd(2'd0, 32'h0000_0001, "ctrl_before_rst");
    wait_k(50);
    chk("arst_pre_r", {31'b0, rgb_pwm[0]}, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rgb", {29'b0, rgb_pwm}, 0);
    chk("arst_dout", dout, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) rd(a[1:0], 32'h0, "arst_reg");
    repeat (3) @(negedge clk);
    chk("arst_rgb_idle", {29'b0, rgb_pwm}, 0);
    chk("sb_drain", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
